// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake sprite pipeline.
//   dir_t         - snake heading, packed into the top bits of the sprite ROM address
//   SCREEN_W/H    - visible raster size
//   SPRITE_ADDR_W - sprite ROM address width {dir, frame, row, col}
//   in_span()     - 11-bit range test used by the bounding-box hit logic
package snake_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int SPRITE_ADDR_W = 13;

  // True when base <= c < base + size. Evaluated at 11 bits so a sprite
  // near the right/bottom edge never wraps back to column/row 0.
  function automatic logic in_span(input logic [10:0] c,
                                   input logic [10:0] base,
                                   input logic [10:0] size);
    return (c >= base) && (c < (base + size));
  endfunction

endpackage

// File: rtl/snake_anim_ctr.sv
// snake_anim_ctr: two-frame walk animation for the snake sprite.
//   Clk        in  pixel clock
//   Reset_n    in  asynchronous active-low reset
//   frame_tick in  one-cycle pulse per video frame
//   moving_q   in  latched animation enable
//   frame      out current animation frame (toggles every FRAME_PERIOD ticks)
module snake_anim_ctr #(
  parameter int FRAME_PERIOD = 15
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_tick,
  input  logic moving_q,
  output logic frame
);

  localparam int CNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(FRAME_PERIOD - 1);

  logic [CNT_W-1:0] r_tick_cnt;
  logic             r_frame;

  // While the snake is stopped both the count and the frame freeze, so it
  // resumes walking from the same pose.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tick_cnt <= '0;
      r_frame    <= 1'b0;
    end else if (frame_tick && moving_q) begin
      if (r_tick_cnt == LAST_TICK) begin
        r_tick_cnt <= '0;
        r_frame    <= ~r_frame;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  assign frame = r_frame;

endmodule

// File: rtl/snake_sprite_fetch.sv
// snake_sprite_fetch: beam hit test and sprite ROM fetch for the snake.
//   Clk, Reset_n        pixel clock, asynchronous active-low reset
//   frame_tick          start-of-vblank pulse; loads position/dir/moving
//   blank               beam outside visible area
//   DrawX, DrawY        beam position
//   SnakeX, SnakeY      sprite top-left (sampled on frame_tick)
//   dir, moving         heading and animation enable (sampled on frame_tick)
//   rom_addr            {dir, frame, row, col} to synchronous sprite ROM
//   rom_data            ROM palette index, one edge after rom_addr
//   pix_index/pix_valid opaque snake pixel, 2 edges after DrawX/DrawY
module snake_sprite_fetch
  import snake_pkg::*;
#(
  parameter int         SPRITE_W        = 32,
  parameter int         SPRITE_H        = 32,
  parameter int         FRAME_PERIOD    = 15,
  parameter logic [3:0] TRANSPARENT_IDX = 4'd0
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_tick,
  input  logic                     blank,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic [9:0]               SnakeX,
  input  logic [9:0]               SnakeY,
  input  dir_t                     dir,
  input  logic                     moving,
  output logic [SPRITE_ADDR_W-1:0] rom_addr,
  input  logic [3:0]               rom_data,
  output logic [3:0]               pix_index,
  output logic                     pix_valid
);

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  // Frame-stable copies of the sprite placement
  logic [9:0] r_pos_x;
  logic [9:0] r_pos_y;
  dir_t       r_dir_q;
  logic       r_moving_q;
  logic       w_frame;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pos_x    <= '0;
      r_pos_y    <= '0;
      r_dir_q    <= RIGHT;
      r_moving_q <= 1'b0;
    end else if (frame_tick) begin
      r_pos_x    <= SnakeX;
      r_pos_y    <= SnakeY;
      r_dir_q    <= dir;
      r_moving_q <= moving;
    end
  end

  snake_anim_ctr #(
    .FRAME_PERIOD (FRAME_PERIOD)
  ) u_anim_ctr (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .moving_q   (r_moving_q),
    .frame      (w_frame)
  );

  // Hit test and address formation
  logic             w_hit;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [SPRITE_ADDR_W-1:0] w_addr;

  assign w_hit = in_span({1'b0, DrawX}, {1'b0, r_pos_x}, 11'(SPRITE_W)) &&
                 in_span({1'b0, DrawY}, {1'b0, r_pos_y}, 11'(SPRITE_H));

  // Sprite dimensions are powers of two, so the low bits of the offset are
  // the in-sprite coordinate whenever w_hit is set.
  assign w_col  = COL_W'(DrawX - r_pos_x);
  assign w_row  = ROW_W'(DrawY - r_pos_y);
  assign w_addr = w_hit ? SPRITE_ADDR_W'({r_dir_q, w_frame, w_row, w_col})
                        : '0;

  // Pipeline: stage 1 presents the ROM address, stage 2 waits for ROM data,
  // stage 3 registers the palette output.
  logic [SPRITE_ADDR_W-1:0] r_rom_addr;
  logic                     r_hit_d1;
  logic                     r_hit_d2;
  logic                     r_blank_d1;
  logic                     r_blank_d2;
  logic [3:0]               r_pix_index;
  logic                     r_pix_valid;
  logic                     w_pix_valid_next;

  assign w_pix_valid_next = r_hit_d2 && !r_blank_d2 && (rom_data != TRANSPARENT_IDX);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr  <= '0;
      r_hit_d1    <= 1'b0;
      r_hit_d2    <= 1'b0;
      r_blank_d1  <= 1'b0;
      r_blank_d2  <= 1'b0;
      r_pix_index <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_rom_addr  <= w_addr;
      r_hit_d1    <= w_hit;
      r_blank_d1  <= blank;
      r_hit_d2    <= r_hit_d1;
      r_blank_d2  <= r_blank_d1;
      r_pix_valid <= w_pix_valid_next;
      r_pix_index <= w_pix_valid_next ? rom_data : 4'd0;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign pix_index = r_pix_index;
  assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_snake_sprite_fetch.sv
module tb_snake_sprite_fetch;
  import snake_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        blank = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [9:0]  SnakeX = '0;
  logic [9:0]  SnakeY = '0;
  dir_t        dir = RIGHT;
  logic        moving = 1'b0;
  logic [12:0] rom_addr;
  logic [3:0]  rom_data = 4'd0;
  logic [3:0]  pix_index;
  logic        pix_valid;

  snake_sprite_fetch dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .blank      (blank),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .SnakeX     (SnakeX),
    .SnakeY     (SnakeY),
    .dir        (dir),
    .moving     (moving),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_index  (pix_index),
    .pix_valid  (pix_valid)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM model
  logic [3:0] rom_mem [0:8191];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  // Reference model state
  int         m_px, m_py, m_tick;
  logic [1:0] m_dir;
  bit         m_mov, m_frame;

  typedef struct {
    logic       pv;
    logic [3:0] pi;
    int         x;
    int         y;
  } exp_t;

  logic [12:0] addr_q[$];
  exp_t        pix_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    exp_t z;
    m_px = 0; m_py = 0; m_tick = 0;
    m_dir = RIGHT; m_mov = 0; m_frame = 0;
    addr_q.delete();
    pix_q.delete();
    z.pv = 1'b0; z.pi = 4'd0; z.x = -1; z.y = -1;
    // Outputs must read zero for the first edges after release
    repeat (3) pix_q.push_back(z);
  endtask

  // One pixel per clock: check matured expectations, push new, drive, advance.
  task automatic cycle(input int x, input int y, input bit bl, input bit ft);
    exp_t        e;
    logic [12:0] a;
    bit          hit;
    if (addr_q.size() == 1) check_val("rom_addr", {19'd0, rom_addr}, {19'd0, addr_q.pop_front()});
    if (pix_q.size() == 3) begin
      e = pix_q.pop_front();
      check_val("pix_valid", {31'd0, pix_valid}, {31'd0, e.pv});
      check_val("pix_index", {28'd0, pix_index}, {28'd0, e.pi});
      $display("px (%0d,%0d) valid=%0b index=%0d", e.x, e.y, pix_valid, pix_index);
    end
    hit = (x >= m_px) && (x < m_px + 32) && (y >= m_py) && (y < m_py + 32);
    a = hit ? {m_dir, m_frame, 5'(y - m_py), 5'(x - m_px)} : 13'd0;
    e.pv = hit && !bl && (rom_mem[a] != 4'd0);
    e.pi = e.pv ? rom_mem[a] : 4'd0;
    e.x = x; e.y = y;
    addr_q.push_back(a);
    pix_q.push_back(e);
    DrawX = 10'(x); DrawY = 10'(y); blank = bl; frame_tick = ft;
    if (ft) begin
      if (m_mov) begin
        if (m_tick == 14) begin m_tick = 0; m_frame = ~m_frame; end
        else m_tick++;
      end
      m_px = int'(SnakeX); m_py = int'(SnakeY); m_dir = dir; m_mov = moving;
    end
    @(negedge Clk);
  endtask

  initial begin
    int clip_x[7];
    for (int i = 0; i < 8192; i++) rom_mem[i] = 4'($urandom_range(1, 15));
    rom_mem[0] = 4'd6;   // top-left corner
    rom_mem[1] = 4'd0;   // transparent pixel at (101,50)
    rom_mem[2] = 4'd9;   // opaque pixel probed during blank

    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    reset_model();

    // Place sprite at (100,50), heading right
    SnakeX = 10'd100; SnakeY = 10'd50; dir = RIGHT; moving = 1'b0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(100, 50, 0, 0);
    cycle(131, 81, 0, 0);
    cycle(132, 50, 0, 0);
    cycle(99, 50, 0, 0);
    cycle(101, 50, 0, 0);
    cycle(102, 50, 1, 0);
    cycle(115, 60, 0, 0);

    // Animation: enable, then 15 counted ticks flip the frame
    moving = 1'b1;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, 0, 1);
      cycle(110 + i, 55, 0, 0);
    end
    moving = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 0, 0, 1);
      cycle(120, 70 - (i % 5), 0, 0);
    end

    // Changes without frame_tick must not take effect
    SnakeX = 10'd200; dir = UP;
    cycle(100, 50, 0, 0);
    cycle(105, 52, 0, 0);
    cycle(200, 50, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(200, 50, 0, 0);
    cycle(231, 60, 0, 0);
    cycle(100, 50, 0, 0);

    // Asynchronous reset while an opaque pixel is on the output
    cycle(205, 55, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_val("pre_rst_valid", {31'd0, pix_valid}, {31'd0, pix_q[0].pv});
    #2 Reset_n = 1'b0;
    #1;
    check_val("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check_val("rst_pix_index", {28'd0, pix_index}, 32'd0);
    check_val("rst_rom_addr", {19'd0, rom_addr}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    reset_model();

    // Clipping at the right edge
    SnakeX = 10'd620; SnakeY = 10'd100; dir = DOWN; moving = 1'b0;
    cycle(0, 0, 0, 1);
    clip_x = '{620, 625, 639, 0, 5, 11, 619};
    foreach (clip_x[i]) cycle(clip_x[i], 110, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snake_sprite_fetch.md
# snake_sprite_fetch

Upstream pixel stage for the snake sprite. It decides whether the current VGA beam position falls inside the snake's 32×32 bounding box, builds the sprite ROM address from the latched direction, animation frame and in-sprite row/column, and waits for the synchronous ROM read. It then emits a 4-bit palette index with a valid flag to the snake palette lookup, which converts it to RGB for the colour mapper.

## Interface
- SPRITE_W, 32: sprite width in pixels; power of two.
- SPRITE_H, 32: sprite height in pixels; power of two.
- FRAME_PERIOD, 15: number of vsync ticks between animation frame toggles.
- TRANSPARENT_IDX, 0: palette index treated as see-through.

- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- blank  in  1  high when the beam is outside the visible area
- DrawX  in  10  current beam column
- DrawY  in  10  current beam row
- SnakeX  in  10  sprite top-left column, sampled only on frame_tick
- SnakeY  in  10  sprite top-left row, sampled only on frame_tick
- dir  in  2  snake_pkg::dir_t, sampled only on frame_tick
- moving  in  1  animation enable, sampled only on frame_tick
- rom_addr  out  13  {dir, frame, row[4:0], col[4:0]} to the synchronous sprite ROM
- rom_data  in  4  palette index; valid one edge after rom_addr
- pix_index  out  4  palette index for the palette stage
- pix_valid  out  1  high when the pixel is an opaque snake pixel

## Operation
- **Position latches.** pos_x, pos_y, dir_q and moving_q load from their inputs at any edge where frame_tick=1. They hold otherwise, so the sprite cannot tear mid-frame.
- **Animation counter.**
  - tick_cnt counts frame_tick pulses only while moving_q=1. It is 4 bits, sized to cover FRAME_PERIOD.
  - When tick_cnt = FRAME_PERIOD−1 and frame_tick=1: tick_cnt←0 and frame←~frame.
  - When moving_q=0: tick_cnt holds and frame holds.
- **Hit test.** Arithmetic is done at 11 bits to avoid wrap.
  - hit = (DrawX ≥ pos_x) && (DrawX < pos_x+SPRITE_W) && (DrawY ≥ pos_y) && (DrawY < pos_y+SPRITE_H).
  - A sprite extending past x=639 or y=479 clips naturally; there is no wrap to the left or top edge.
- **Address generation.**
  - col = (DrawX−pos_x)[4:0] and row = (DrawY−pos_y)[4:0].
  - rom_addr = {dir_q, frame, row, col}.
  - When hit=0, rom_addr is forced to 0.
- **Output.**
  - pix_valid = hit_d2 && !blank_d2 && (rom_data ≠ TRANSPARENT_IDX).
  - pix_index = rom_data when pix_valid=1, otherwise 0.
- **Simultaneous events.** On an edge with frame_tick=1, the latches and the frame toggle update together. In-flight pipeline pixels keep the values they captured earlier.

## Timing
- **Reset values.** rom_addr=0, pix_index=0, pix_valid=0; pos_x=pos_y=0, dir_q=RIGHT, moving_q=0, frame=0, tick_cnt=0.
  - All pipeline flops, including hit_d1/d2 and blank_d1/d2, clear asynchronously.
  - An assertion mid-line drops pix_valid immediately.
- **Pipeline.**
  - Inputs are sampled at edge E; rom_addr, hit_d1 and blank_d1 update at E.
  - The ROM registers rom_data at E+1; hit_d2 and blank_d2 update at E+1.
  - pix_index and pix_valid update at E+2.
  - Fixed latency is 2 edges, and the block sustains one pixel per clock with no stalls.
  - The downstream colour mapper must delay DrawX/DrawY by 2 to align.
- **First cycles after reset release.** pix_valid stays 0 for at least 2 edges.

## Structure
- **snake_pkg** holds:
  - dir_t enum: RIGHT=2'd0, LEFT=2'd1, UP=2'd2, DOWN=2'd3.
  - SCREEN_W=640 and SCREEN_H=480.
  - SPRITE_ADDR_W=13.
- **Sub-module snake_anim_ctr** holds tick_cnt and frame. Its inputs are Clk, Reset_n, frame_tick and moving_q; its output is frame.
- The ROM is external to this block.

## Test plan
- **Hit at top-left corner.** frame_tick with SnakeX=100, SnakeY=50, dir=RIGHT; beam at (100,50), rom_data=6 → rom_addr=0x0000, and 2 edges later pix_index=6, pix_valid=1.
- **Box edges.** Beam at (131,81) → rom_addr={0,0,31,31}=0x03FF. Beam at (132,50) → rom_addr=0, pix_valid=0. Beam at (99,50) → pix_valid=0.
- **Transparency and blank.** Inside the box with rom_data=0 → pix_valid=0, pix_index=0. Inside the box with rom_data=9 and blank=1 → pix_valid=0.
- **Animation.** moving=1, then 15 frame_ticks → frame=1, and rom_addr bit 10 is set for hits. moving=0 → frame holds across 30 ticks.
- **Mid-frame change and direction mapping.** SnakeX changed to 200 and dir=UP without a frame_tick → addresses still use pos_x=100 and dir RIGHT. After frame_tick → bits [12:11]=2'b10.
- **Reset and clipping.** Reset_n low while pix_valid=1 → pix_valid=0 immediately with no clock edge. SnakeX=620 → hits only for DrawX in 620..639, with no hit at DrawX=0..11.
